// File: rtl/step_generator_pkg.sv
// step_generator_pkg: shared state encodings and step timing rules for the stepper path
package step_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } step_state_e;

    localparam int DEF_STEP_HIGH = 4;
    localparam int DEF_DIR_SETUP = 4;

    // Shortest legal rise-to-rise period: high time plus two low clocks so the
    // driver's two-flop edge detector always sees the low phase.
    function automatic int min_period(input int step_high);
        return step_high + 2;
    endfunction

endpackage

// File: rtl/step_cmd_buffer.sv
// step_cmd_buffer: one-entry holding register for a pending {dir, steps, period} command
module step_cmd_buffer
    import step_generator_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PER_W = 24
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clr_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] steps_i,
    input  logic [PER_W-1:0] period_i,
    output logic             full_o,
    output logic             dir_o,
    output logic [CNT_W-1:0] steps_o,
    output logic [PER_W-1:0] period_o
);

    logic             full_q, full_d;
    logic             dir_q;
    logic [CNT_W-1:0] steps_q;
    logic [PER_W-1:0] period_q;

    // Slot occupancy: a clear (abort) wins; push and pop never coincide because push needs an empty slot.
    always_comb full_d = clr_i ? 1'b0 : push_i ? 1'b1 : pop_i ? 1'b0 : full_q;

    // Occupancy flag and the captured command fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_q   <= 1'b0;
            dir_q    <= 1'b0;
            steps_q  <= '0;
            period_q <= '0;
        end else begin
            full_q <= full_d;
            if (push_i) begin
                dir_q    <= dir_i;
                steps_q  <= steps_i;
                period_q <= period_i;
            end
        end
    end

    assign full_o   = full_q;
    assign dir_o    = dir_q;
    assign steps_o  = steps_q;
    assign period_o = period_q;

endmodule

// File: rtl/step_generator.sv
// step_generator: turns buffered move commands into step/dir pulses and tracks absolute position
module step_generator
    import step_generator_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int PER_W     = 24,
    parameter int POS_W     = 32,
    parameter int STEP_HIGH = DEF_STEP_HIGH,
    parameter int DIR_SETUP = DEF_DIR_SETUP
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position,
    output logic [CNT_W-1:0] steps_left
);

    localparam logic [PER_W-1:0] MIN_PER  = PER_W'(min_period(STEP_HIGH));
    localparam logic [PER_W-1:0] HIGH_LD  = PER_W'(STEP_HIGH - 1);
    localparam logic [PER_W-1:0] SETUP_LD = PER_W'(DIR_SETUP - 1);
    localparam logic [PER_W-1:0] LOW_OFS  = PER_W'(STEP_HIGH + 1);
    localparam logic [PER_W-1:0] T_ONE    = PER_W'(1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [POS_W-1:0] P_ONE    = POS_W'(1);

    step_state_e      state_q, state_d;
    logic [PER_W-1:0] timer_q, timer_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    logic             pend_full, pend_dir;
    logic [CNT_W-1:0] pend_steps;
    logic [PER_W-1:0] pend_period, pend_eff;
    logic             push, take, rise, stop, tmo;

    // Ready depends only on the registered slot flag and the abort level, never on cmd_valid.
    assign cmd_ready = ~pend_full & ~abort;
    assign push      = cmd_valid & cmd_ready;
    assign pend_eff  = (pend_period < MIN_PER) ? MIN_PER : pend_period;
    assign tmo       = (timer_q == '0);

    step_cmd_buffer #(
        .CNT_W (CNT_W),
        .PER_W (PER_W)
    ) u_buf (
        .clk      (clk),
        .resetn   (resetn),
        .push_i   (push),
        .pop_i    (take),
        .clr_i    (stop),
        .dir_i    (cmd_dir),
        .steps_i  (cmd_steps),
        .period_i (cmd_period),
        .full_o   (pend_full),
        .dir_o    (pend_dir),
        .steps_o  (pend_steps),
        .period_o (pend_period)
    );

    // Next state: per-state timer countdown, then shared load / rise / stop actions applied in priority order.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        per_d   = per_q;
        left_d  = left_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        take    = 1'b0;
        rise    = 1'b0;
        stop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stop = abort & pend_full;
                take = ~abort & pend_full;
            end
            ST_SETUP: begin
                timer_d = timer_q - T_ONE;
                stop    = abort;
                rise    = ~abort & tmo;
            end
            ST_HIGH: begin
                timer_d = timer_q - T_ONE;
                abort_d = abort_q | abort;
                if (tmo) begin
                    stop    = abort_d;
                    state_d = ST_LOW;
                    timer_d = per_q - LOW_OFS;
                end
            end
            ST_LOW: begin
                timer_d = timer_q - T_ONE;
                stop    = abort;
                if (!abort && tmo) begin
                    state_d = ST_IDLE;
                    rise    = (left_q != '0);
                    done_d  = (left_q == '0);
                    take    = (left_q == '0) & pend_full & (pend_steps != '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            per_d  = pend_eff;
            left_d = pend_steps;
            if (pend_steps == '0) begin
                done_d = 1'b1;
            end else if (pend_dir != dir_q) begin
                dir_d   = pend_dir;
                state_d = ST_SETUP;
                timer_d = SETUP_LD;
            end else begin
                rise = 1'b1;
            end
        end
        if (rise) begin
            state_d = ST_HIGH;
            timer_d = HIGH_LD;
            left_d  = left_d - C_ONE;
            pos_d   = dir_d ? pos_q + P_ONE : pos_q - P_ONE;
        end
        if (stop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            left_d  = '0;
            abort_d = 1'b0;
        end
        step_d = (state_d == ST_HIGH);
    end

    // State and output registers; reset drops step immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            per_q   <= '0;
            left_q  <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            per_q   <= per_d;
            left_q  <= left_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign step       = step_q;
    assign dir        = dir_q;
    assign done       = done_q;
    assign position   = pos_q;
    assign steps_left = left_q;
    assign busy       = (state_q != ST_IDLE) | pend_full;

endmodule
